// File: rtl/resp_signature_monitor.sv
// Response signature compactor: folds each accepted DUT output sample slice-by-slice
// through a Galois LFSR and reports done/match after a fixed number of samples.
module resp_signature_monitor #(
  parameter int          Y_WIDTH = 501,
  parameter int          SLICE   = 32,
  parameter int          SAMPLES = 21,
  parameter logic [31:0] POLY    = 32'h04C1_1DB7,
  parameter logic [31:0] SEED    = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               start,
  input  logic [31:0]        expected,
  output logic [31:0]        signature,
  output logic [7:0]         sample_count,
  output logic [7:0]         drop_count,
  output logic               done,
  output logic               match
);

  localparam int NSLICE = (Y_WIDTH + SLICE - 1) / SLICE;
  localparam int PADW   = NSLICE * SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [SLICE-1:0] r_buf [NSLICE];
  logic [PADW-1:0]  w_padded;
  logic [KW-1:0]    r_k;
  logic [31:0]      r_sig;
  logic [31:0]      w_step;
  logic [31:0]      w_sigNext;
  logic [7:0]       r_count;
  logic [7:0]       w_countNext;
  logic [7:0]       r_drop;
  logic             r_match;
  logic             w_accept;
  logic             w_lastSlice;
  logic             w_lastSample;

  // Pad bits above Y_WIDTH are forced to zero so they never disturb the signature.
  always_comb begin
    w_padded              = '0;
    w_padded[Y_WIDTH-1:0] = y_in;
  end

  assign w_accept     = in_valid && in_ready;
  assign w_lastSlice  = (r_k == KW'(NSLICE - 1));
  assign w_countNext  = r_count + 8'd1;
  assign w_lastSample = (w_countNext == 8'(SAMPLES));
  assign w_step       = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0);
  assign w_sigNext    = w_step ^ r_buf[r_k];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (start) begin
      w_nextState = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (in_valid) w_nextState = FOLD;
        FOLD:    if (w_lastSlice) w_nextState = w_lastSample ? DONE : IDLE;
        DONE:    w_nextState = DONE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == IDLE) && !start;
    done     = (r_state == DONE);
  end

  // Capture buffer holds the sample stable for the whole fold window; it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NSLICE; i++) r_buf[i] <= w_padded[i*SLICE +: SLICE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig   <= SEED;
      r_k     <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_match <= 1'b0;
    end else begin
      if (in_valid && !in_ready && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      if (start) begin
        r_sig   <= SEED;
        r_k     <= '0;
        r_count <= '0;
        r_match <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: if (w_accept) r_k <= '0;
          FOLD: begin
            r_sig <= w_sigNext;
            r_k   <= r_k + KW'(1);
            if (w_lastSlice) begin
              r_count <= w_countNext;
              if (w_lastSample) r_match <= (w_sigNext == expected);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign signature    = r_sig;
  assign sample_count = r_count;
  assign drop_count   = r_drop;
  assign match        = r_match;

endmodule

// File: doc/resp_signature_monitor.md
# resp_signature_monitor

Response-side companion to the stimulus testbenches: it consumes the wide `y` output vector of a synthesized `top` and compacts successive samples into a 32-bit signature. One signature comparison then replaces per-cycle `$strobe` diffing between simulator and synthesis runs. The block sits between the DUT output (or a capture FIFO) and the pass/fail logic. It folds each accepted sample slice-by-slice through a Galois LFSR and, after a programmed number of samples, reports done/match against an expected signature.

## Interface
- `Y_WIDTH`, 501: width of the sampled DUT output.
- `SLICE`, 32: fold slice width; equals signature width.
- `SAMPLES`, 21: number of samples that completes a run (1..255).
- `POLY`, 32'h04C1_1DB7: Galois feedback polynomial.
- `SEED`, 32'hFFFF_FFFF: signature value after reset and after `start`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `y_in` in Y_WIDTH: sample data; must be stable while `in_valid`.
- `in_valid` in 1: sample offered.
- `in_ready` out 1: sample accepted on a rising edge where `in_valid && in_ready`.
- `start` in 1: synchronous run restart, one-cycle pulse.
- `expected` in 32: reference signature; sampled when entering DONE.
- `signature` out 32: running signature.
- `sample_count` out 8: samples fully folded in this run.
- `drop_count` out 8: cycles with `in_valid && !in_ready`; saturates at 255.
- `done` out 1: run complete.
- `match` out 1: `signature == expected` at completion; valid only while `done`.

## Operation
- `NSLICE = ceil(Y_WIDTH/SLICE)`, which is 16 at the default. The sample is zero-padded to `NSLICE*SLICE` bits. Slice k is `padded[k*SLICE +: SLICE]`.
- States:
  - IDLE: `in_ready=1`.
  - FOLD: `in_ready=0`; slice index k runs 0..NSLICE-1.
  - DONE: `in_ready=0`, `done=1`.
- IDLE→FOLD on accept. The sample is registered into a capture buffer and k=0.
- FOLD: each cycle, `signature <= step(signature) ^ slice[k]`, then k++.
  - `step(s) = (s << 1) ^ (s[31] ? POLY : 0)`.
  - The first fold cycle applies `step` to the pre-sample signature, so SEED=0 with an empty slice stays 0.
- At k=NSLICE-1: `sample_count++`.
  - If the new count equals SAMPLES, go to DONE and latch `match`.
  - Otherwise return to IDLE.
- DONE holds all outputs until `start` or `rst`.
- `start`, in any state: signature←SEED, sample_count←0, match←0, k←0, state←IDLE. `drop_count` is unchanged.
  - `start` beats `in_valid` in the same cycle: `in_ready` is 0 while `start` is high, so no accept occurs.
- `start` during FOLD aborts the partial sample; none of its slices remain in the signature.
- `drop_count` increments in any non-reset cycle with `in_valid && !in_ready`, including DONE. It saturates at 255 and is cleared only by `rst`.

## Timing
- Reset values: state IDLE, `in_ready=1`, `signature=SEED`, `sample_count=0`, `drop_count=0`, `done=0`, `match=0`.
- Throughput: one sample per NSLICE+1 cycles (17 at default). Accept is at edge t, fold edges are t+1..t+16, and `in_ready` is high again after edge t+16.
- `signature` updates at each fold edge; intermediate values are visible.
- `done` and `match` assert after the final fold edge: last accept edge +16.
- `in_ready` is combinational from state and `start`; all other outputs are registered.
- `rst` mid-FOLD returns to reset values immediately; the capture buffer content is don't-care.

## Test plan
- SEED=0, SAMPLES=1, y_in=1 (bit 0 only):
  - signature is 32'h0000_0001 after fold edge 1.
  - After 16 fold edges, `done=1` and signature=32'h0000_8000.
  - expected=32'h0000_8000 → match=1.
- SEED=0, SAMPLES=1, y_in with only bit 500 set → final signature=32'h0010_0000. Stimulus with only bit 511 set is not expressible: pad bits are forced to 0.
- Back-to-back: `in_valid` held high for 40 cycles, SAMPLES=2.
  - Accepts at cycles 0 and 17.
  - `done` after the fold of the second sample.
  - `drop_count`: 32 at `done` (16 per fold window), reaching 38 by the end of the 40 cycles as it keeps counting in DONE.
- `start` on fold edge 7 of sample 1:
  - signature returns to SEED and `sample_count=0`.
  - Re-feeding the same 21 vectors gives a signature identical to an uninterrupted run.
- `rst` asserted asynchronously mid-FOLD: all outputs take reset values before the next clock edge; a subsequent run matches the golden signature.
- Determinism: the default 21-vector testbench sequence from the yosys-synthesized and reference-simulated `top` produces equal signatures, and match=1 when `expected` is taken from either run.
